dual_issue_fetch_queue: RTL and testbench
=========================================

DUAL_ISSUE_FETCH_QUEUE -- requirements
Module: dual_issue_fetch_queue

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising-edge; reset  in  1  asynchronous, active-low reset.
REQ-002 SHALL have: fq_in0_valid  in  1  fetch slot 0 valid; fq_in0_instr  in  32  slot 0 instruction; fq_in0_pc  in  8  slot 0 PC; fq_in0_pred  in  1  slot 0 BPU prediction.
REQ-003 SHALL have: fq_in1_valid  in  1  fetch slot 1 valid; fq_in1_instr  in  32; fq_in1_pc  in  8; fq_in1_pred  in  1 (same meanings for slot 1).
REQ-004 SHALL have: fq_ready  out  1  queue can accept two entries this cycle.
REQ-005 SHALL have: issue0_valid / issue1_valid  out  1  oldest / second-oldest entry valid; issue0_instr / issue1_instr  out  32; issue0_pc / issue1_pc  out  8; issue0_pred / issue1_pred  out  1.
REQ-006 SHALL have: dec_take  in  2  number of entries decode consumes (0, 1 or 2).
REQ-007 SHALL have: stall_inner, stall_outer  in  1  decode stall; flush1_J, flush_JB, flush1_JR, flush2_JR, flush1_B, flush2_B  in  1  redirect flushes.
REQ-008 SHALL have: fq_count  out  4  current occupancy, 0..8.

Function
REQ-009 SHALL store 8 entries of {instr[31:0], pc[7:0], pred}, circular, 3-bit head/tail pointers wrapping modulo 8.
REQ-010 SHALL drive fq_ready = 1 iff fq_count <= 6, combinationally from current count.
REQ-011 SHALL push on a rising edge only when fq_ready = 1: slot 0 if fq_in0_valid; slot 1 if fq_in1_valid; slot 1 written at tail+1 when both valid, at tail when only slot 1 valid.
REQ-012 SHALL ignore all pushes while fq_ready = 0; no entry overwritten, no error flagged.
REQ-013 SHALL drive issue0_* from head and issue1_* from head+1 (mod 8), combinational; issue0_valid = (count >= 1), issue1_valid = (count >= 2).
REQ-014 SHALL force every issue data field to zero when its valid is 0 (bubble convention).
REQ-015 SHALL compute pop = min(dec_take, count) when stall_inner = stall_outer = 0; pop = 0 on any stall; dec_take = 3 treated as 2.
REQ-016 SHALL update count_next = count + pushes - pop in one cycle; simultaneous push and pop legal at any occupancy including full and empty.
REQ-017 SHALL, when any flush input is 1 at a rising edge, set head = tail = 0 and count = 0 and discard same-cycle pushes and pops; flush takes priority over stall and push.
REQ-018 SHALL have one-cycle latency: an entry pushed at edge N is visible on issue0/issue1 after edge N.
REQ-019 SHALL preserve program order: slot 0 precedes slot 1, earlier cycles precede later.

Reset
REQ-020 SHALL on reset = 0, asynchronously, clear head, tail, count to 0; all issue outputs 0; fq_ready = 1; storage contents need not be cleared.
REQ-021 SHALL, on reset asserted mid-operation, discard all entries; first post-release edge behaves as empty queue.

Configuration
REQ-022 SHALL support macro FETCHQ_PERF_EN: when defined, add output perf_stall_cnt  out  16, counting cycles with (stall_inner | stall_outer) & issue0_valid, saturating at 16'hFFFF, cleared only by reset.
REQ-023 SHALL, without FETCHQ_PERF_EN, omit perf_stall_cnt and its counter entirely; all other behaviour identical.

Verification
REQ-024 SHALL cover: after reset, push {in0 instr=32'h11, pc=8'h04; in1 instr=32'h22, pc=8'h05}, dec_take=0 -> next cycle issue0_instr=32'h11, issue1_instr=32'h22, fq_count=2.
REQ-025 SHALL cover: fill to 7 entries -> fq_ready=0; push both slots -> fq_count stays 7, contents unchanged.
REQ-026 SHALL cover: count=8, push ignored, dec_take=2 -> count=6, next-cycle fq_ready=1, issue0 = third-oldest entry.
REQ-027 SHALL cover: count=5, stall_outer=1, dec_take=2, push 2 -> count=7 (no pop).
REQ-028 SHALL cover: count=4, flush1_B=1 with push 2 and dec_take=2 -> count=0, issue0_valid=0, all issue fields 0.
REQ-029 SHALL cover: 20 cycles of push 2 / take 2 from count=2 -> pointers wrap, order preserved, count constant 2; with FETCHQ_PERF_EN, 3 stall cycles with count>0 -> perf_stall_cnt=3.

Source files
------------

// File: rtl/dual_issue_fetch_queue.sv
// Eight-entry circular fetch queue. It accepts two fetch slots per cycle and presents the two oldest entries to decode.
// Optional build macro FETCHQ_PERF_EN adds the perf_stall_cnt decode-stall counter output.
module dual_issue_fetch_queue (
    input  logic        clk,
    input  logic        reset,
    input  logic        fq_in0_valid,
    input  logic [31:0] fq_in0_instr,
    input  logic [7:0]  fq_in0_pc,
    input  logic        fq_in0_pred,
    input  logic        fq_in1_valid,
    input  logic [31:0] fq_in1_instr,
    input  logic [7:0]  fq_in1_pc,
    input  logic        fq_in1_pred,
    output logic        fq_ready,
    output logic        issue0_valid,
    output logic [31:0] issue0_instr,
    output logic [7:0]  issue0_pc,
    output logic        issue0_pred,
    output logic        issue1_valid,
    output logic [31:0] issue1_instr,
    output logic [7:0]  issue1_pc,
    output logic        issue1_pred,
    input  logic [1:0]  dec_take,
    input  logic        stall_inner,
    input  logic        stall_outer,
    input  logic        flush1_J,
    input  logic        flush_JB,
    input  logic        flush1_JR,
    input  logic        flush2_JR,
    input  logic        flush1_B,
    input  logic        flush2_B,
`ifdef FETCHQ_PERF_EN
    output logic [15:0] perf_stall_cnt,
`endif
    output logic [3:0]  fq_count
);
    localparam int DEPTH = 8;

    logic [31:0] r_instr [DEPTH];
    logic [7:0]  r_pc    [DEPTH];
    logic        r_pred  [DEPTH];
    logic [2:0]  r_head;
    logic [2:0]  r_tail;
    logic [3:0]  r_count;

    logic        w_flush;
    logic        w_stall;
    logic        w_push0;
    logic        w_push1;
    logic [1:0]  w_npush;
    logic [1:0]  w_take;
    logic [1:0]  w_pop;
    logic [2:0]  w_head1;
    logic [2:0]  w_slot1_idx;

    assign w_flush  = flush1_J | flush_JB | flush1_JR | flush2_JR | flush1_B | flush2_B;
    assign w_stall  = stall_inner | stall_outer;
    assign fq_ready = (r_count <= 4'd6);
    assign w_push0  = fq_ready & fq_in0_valid;
    assign w_push1  = fq_ready & fq_in1_valid;
    assign w_npush  = {1'b0, w_push0} + {1'b0, w_push1};
    assign w_take   = (dec_take == 2'd3) ? 2'd2 : dec_take;
    // Slot 1 packs behind slot 0 only when slot 0 is also written this cycle.
    assign w_slot1_idx = w_push0 ? (r_tail + 3'd1) : r_tail;
    assign w_head1     = r_head + 3'd1;

    always_comb begin
        w_pop = 2'd0;
        if (!w_stall) begin
            if ({2'b00, w_take} > r_count)
                w_pop = r_count[1:0];
            else
                w_pop = w_take;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= 3'd0;
            r_tail  <= 3'd0;
            r_count <= 4'd0;
        end else if (w_flush) begin
            r_head  <= 3'd0;
            r_tail  <= 3'd0;
            r_count <= 4'd0;
        end else begin
            r_head  <= r_head + {1'b0, w_pop};
            r_tail  <= r_tail + {1'b0, w_npush};
            r_count <= r_count + {2'b00, w_npush} - {2'b00, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!w_flush) begin
            if (w_push0) begin
                r_instr[r_tail] <= fq_in0_instr;
                r_pc[r_tail]    <= fq_in0_pc;
                r_pred[r_tail]  <= fq_in0_pred;
            end
            if (w_push1) begin
                r_instr[w_slot1_idx] <= fq_in1_instr;
                r_pc[w_slot1_idx]    <= fq_in1_pc;
                r_pred[w_slot1_idx]  <= fq_in1_pred;
            end
        end
    end

    assign fq_count     = r_count;
    assign issue0_valid = (r_count != 4'd0);
    assign issue1_valid = (r_count >= 4'd2);
    // Invalid issue slots read as all-zero bubbles.
    assign issue0_instr = issue0_valid ? r_instr[r_head] : 32'd0;
    assign issue0_pc    = issue0_valid ? r_pc[r_head]    : 8'd0;
    assign issue0_pred  = issue0_valid ? r_pred[r_head]  : 1'b0;
    assign issue1_instr = issue1_valid ? r_instr[w_head1] : 32'd0;
    assign issue1_pc    = issue1_valid ? r_pc[w_head1]    : 8'd0;
    assign issue1_pred  = issue1_valid ? r_pred[w_head1]  : 1'b0;

`ifdef FETCHQ_PERF_EN
    logic [15:0] r_perf_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_perf_stall_cnt <= 16'd0;
        else if (w_stall && issue0_valid && (r_perf_stall_cnt != 16'hFFFF))
            r_perf_stall_cnt <= r_perf_stall_cnt + 16'd1;
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
`endif
endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// Self-checking bench for dual_issue_fetch_queue using a reference queue of expected entries.
// Define FETCHQ_PERF_EN to also check perf_stall_cnt.
module tb_dual_issue_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        fq_in0_valid, fq_in1_valid;
    logic [31:0] fq_in0_instr, fq_in1_instr;
    logic [7:0]  fq_in0_pc, fq_in1_pc;
    logic        fq_in0_pred, fq_in1_pred;
    logic        fq_ready;
    logic        issue0_valid, issue1_valid;
    logic [31:0] issue0_instr, issue1_instr;
    logic [7:0]  issue0_pc, issue1_pc;
    logic        issue0_pred, issue1_pred;
    logic [1:0]  dec_take;
    logic        stall_inner, stall_outer;
    logic        flush1_J, flush_JB, flush1_JR, flush2_JR, flush1_B, flush2_B;
    logic [3:0]  fq_count;
`ifdef FETCHQ_PERF_EN
    logic [15:0] perf_stall_cnt;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [40:0] mq[$];
    logic [15:0] perf_exp = 16'd0;

    always #5 clk = ~clk;

    dual_issue_fetch_queue dut (
        .clk(clk), .reset(reset),
        .fq_in0_valid(fq_in0_valid), .fq_in0_instr(fq_in0_instr), .fq_in0_pc(fq_in0_pc), .fq_in0_pred(fq_in0_pred),
        .fq_in1_valid(fq_in1_valid), .fq_in1_instr(fq_in1_instr), .fq_in1_pc(fq_in1_pc), .fq_in1_pred(fq_in1_pred),
        .fq_ready(fq_ready),
        .issue0_valid(issue0_valid), .issue0_instr(issue0_instr), .issue0_pc(issue0_pc), .issue0_pred(issue0_pred),
        .issue1_valid(issue1_valid), .issue1_instr(issue1_instr), .issue1_pc(issue1_pc), .issue1_pred(issue1_pred),
        .dec_take(dec_take), .stall_inner(stall_inner), .stall_outer(stall_outer),
        .flush1_J(flush1_J), .flush_JB(flush_JB), .flush1_JR(flush1_JR), .flush2_JR(flush2_JR),
        .flush1_B(flush1_B), .flush2_B(flush2_B),
`ifdef FETCHQ_PERF_EN
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .fq_count(fq_count)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int          sz;
        logic [41:0] e0, e1;
        sz = mq.size();
        e0 = (sz >= 1) ? {1'b1, mq[0]} : 42'd0;
        e1 = (sz >= 2) ? {1'b1, mq[1]} : 42'd0;
        chk({tag, ".fq_count"}, 64'(fq_count), 64'(sz));
        chk({tag, ".fq_ready"}, 64'(fq_ready), 64'(sz <= 6));
        chk({tag, ".issue0"}, 64'({issue0_valid, issue0_instr, issue0_pc, issue0_pred}), 64'(e0));
        chk({tag, ".issue1"}, 64'({issue1_valid, issue1_instr, issue1_pc, issue1_pred}), 64'(e1));
`ifdef FETCHQ_PERF_EN
        chk({tag, ".perf"}, 64'(perf_stall_cnt), 64'(perf_exp));
`endif
    endtask

    function automatic logic [40:0] rnd_entry();
        logic [31:0] a, b;
        a = $urandom();
        b = $urandom();
        return {a, b[7:0], b[8]};
    endfunction

    task automatic step_d(input string tag, input logic v0, input logic [40:0] e0,
                          input logic v1, input logic [40:0] e1, input logic [1:0] take,
                          input logic si, input logic so, input logic [5:0] fl);
        int sz, tk, pop;
        {fq_in0_instr, fq_in0_pc, fq_in0_pred} = e0;
        {fq_in1_instr, fq_in1_pc, fq_in1_pred} = e1;
        fq_in0_valid = v0;
        fq_in1_valid = v1;
        dec_take     = take;
        stall_inner  = si;
        stall_outer  = so;
        {flush2_B, flush1_B, flush2_JR, flush1_JR, flush_JB, flush1_J} = fl;
        sz = mq.size();
        if ((si || so) && sz > 0 && perf_exp != 16'hFFFF) perf_exp++;
        if (fl != 6'd0) begin
            mq.delete();
        end else begin
            tk  = (take == 2'd3) ? 2 : int'(take);
            pop = (si || so) ? 0 : ((tk < sz) ? tk : sz);
            repeat (pop) void'(mq.pop_front());
            if (sz <= 6) begin
                if (v0) mq.push_back(e0);
                if (v1) mq.push_back(e1);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic step(input string tag, input logic v0, input logic v1, input logic [1:0] take,
                        input logic si, input logic so, input logic [5:0] fl);
        step_d(tag, v0, rnd_entry(), v1, rnd_entry(), take, si, so, fl);
    endtask

    initial begin
        reset = 1'b0;
        fq_in0_valid = 0; fq_in1_valid = 0;
        fq_in0_instr = 0; fq_in1_instr = 0; fq_in0_pc = 0; fq_in1_pc = 0;
        fq_in0_pred = 0; fq_in1_pred = 0;
        dec_take = 0; stall_inner = 0; stall_outer = 0;
        {flush2_B, flush1_B, flush2_JR, flush1_JR, flush_JB, flush1_J} = 6'd0;
        repeat (2) @(negedge clk);
        check_state("reset");
        reset = 1'b1;

        step_d("first_pair", 1, {32'h11, 8'h04, 1'b0}, 1, {32'h22, 8'h05, 1'b1}, 2'd0, 0, 0, 6'd0);

        for (int i = 0; i < 20; i++) step("wrap", 1, 1, 2'd2, 0, 0, 6'd0);
        step("take3", 0, 0, 2'd3, 0, 0, 6'd0);

        for (int i = 0; i < 3; i++) step("fill", 1, 1, 2'd0, 0, 0, 6'd0);
        step("slot1_only", 0, 1, 2'd0, 0, 0, 6'd0);
        step("full7_push", 1, 1, 2'd0, 0, 0, 6'd0);
        step("to6", 0, 0, 2'd1, 0, 0, 6'd0);
        step("to8", 1, 1, 2'd0, 0, 0, 6'd0);
        step("full8_take2", 1, 1, 2'd2, 0, 0, 6'd0);
        step("to5", 0, 0, 2'd1, 0, 0, 6'd0);
        step("stall_outer", 1, 1, 2'd2, 0, 1, 6'd0);
        step("stall_inner", 0, 0, 2'd2, 1, 0, 6'd0);
        step("stall_both", 0, 0, 2'd2, 1, 1, 6'd0);
        step("drain", 0, 0, 2'd2, 0, 0, 6'd0);
        step("to4", 0, 0, 2'd1, 0, 0, 6'd0);
        step("flush1_B", 1, 1, 2'd2, 0, 0, 6'b010000);

        for (int i = 0; i < 6; i++) begin
            step("preflush", 1, 1, 2'd0, 0, 0, 6'd0);
            step("flush_each", 1, 1, 2'd2, 1, 0, 6'(1 << i));
        end
        step("empty_pushpop", 1, 1, 2'd2, 0, 0, 6'd0);

        for (int i = 0; i < 60; i++) begin
            step("random", 1'($urandom), 1'($urandom), 2'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0);
        end

        step("pre_reset", 1, 1, 2'd0, 0, 0, 6'd0);
        step("pre_reset", 1, 1, 2'd0, 0, 0, 6'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        mq.delete();
        perf_exp = 16'd0;
        check_state("async_reset");
        @(negedge clk);
        reset = 1'b1;
        step("post_reset", 1, 0, 2'd0, 0, 0, 6'd0);
        step("post_reset_pop", 0, 0, 2'd1, 0, 0, 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
